// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package ttt_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    localparam int NUM_LINES = 8;

    // Rows, columns, then the two diagonals; bit n-1 is board position n.
    localparam logic [8:0] WIN_LINES [NUM_LINES] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    localparam logic [8:0] FULL_BOARD = 9'h1FF;

endpackage

// File: rtl/ttt_turn_controller_if.sv
// Move handshake and board status bundle between keypad front end,
// turn controller and display back end.
interface ttt_turn_controller_if;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic [8:0] board_x;
    logic [8:0] board_o;
    logic       turn;
    logic       illegal;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output new_game, move_valid, move_pos,
        input  move_ready, board_x, board_o, turn, illegal, game_over, winner
    );

    modport slave (
        input  new_game, move_valid, move_pos,
        output move_ready, board_x, board_o, turn, illegal, game_over, winner
    );
endinterface

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector for one player's occupancy mask.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0] board,
    output logic       win
);

    // Any line whose every cell is held by this player is a win.
    always_comb begin
        win = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: takes one move per handshake, keeps the two
// occupancy registers, alternates turns and reports win or draw.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   PLAY  | waiting for a move; move_ready high
//   CHECK | one cycle to judge the board just updated; no moves taken
//   DONE  | game finished; all moves ignored until new_game or reset
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0,
    parameter int   CELLS        = 9
) (
    input logic                  clk,
    input logic                  rst_n,
    ttt_turn_controller_if.slave bus
);

    state_t             state_q, state_d;
    logic [CELLS-1:0]   board_x_q, board_x_d;
    logic [CELLS-1:0]   board_o_q, board_o_d;
    logic               turn_q, turn_d;
    logic               illegal_q, illegal_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;

    logic [CELLS-1:0]   move_mask;
    logic               move_legal;
    logic               move_take;
    logic               win_x;
    logic               win_o;
    logic               board_full;

    ttt_line_check u_line_x (.board(board_x_q), .win(win_x));
    ttt_line_check u_line_o (.board(board_o_q), .win(win_o));

    // Position code to one-hot cell; out-of-range codes give an empty mask.
    always_comb begin
        move_mask = '0;
        case (bus.move_pos)
            4'd1:    move_mask = 9'h001;
            4'd2:    move_mask = 9'h002;
            4'd3:    move_mask = 9'h004;
            4'd4:    move_mask = 9'h008;
            4'd5:    move_mask = 9'h010;
            4'd6:    move_mask = 9'h020;
            4'd7:    move_mask = 9'h040;
            4'd8:    move_mask = 9'h080;
            4'd9:    move_mask = 9'h100;
            default: move_mask = '0;
        endcase
    end

    assign move_legal = (move_mask != '0) && ((move_mask & (board_x_q | board_o_q)) == '0);
    assign move_take  = bus.move_valid && (state_q == PLAY);
    assign board_full = ((board_x_q | board_o_q) == FULL_BOARD);

    // State and all status registers; every output comes straight from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLAY;
            board_x_q   <= '0;
            board_o_q   <= '0;
            turn_q      <= FIRST_PLAYER;
            illegal_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            state_q     <= state_d;
            board_x_q   <= board_x_d;
            board_o_q   <= board_o_d;
            turn_q      <= turn_d;
            illegal_q   <= illegal_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    // Next-state: new_game overrides everything, including a pending CHECK.
    always_comb begin
        state_d = state_q;
        if (bus.new_game) begin
            state_d = PLAY;
        end else begin
            case (state_q)
                PLAY:    if (move_take && move_legal) state_d = CHECK;
                CHECK:   state_d = (win_x || win_o || board_full) ? DONE : PLAY;
                DONE:    state_d = DONE;
                default: state_d = PLAY;
            endcase
        end
    end

    // Board, turn and result updates. Turn only flips once the move has been
    // judged not to end the game, so the winner's turn value is left standing.
    always_comb begin
        board_x_d   = board_x_q;
        board_o_d   = board_o_q;
        turn_d      = turn_q;
        illegal_d   = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (bus.new_game) begin
            board_x_d   = '0;
            board_o_d   = '0;
            turn_d      = FIRST_PLAYER;
            game_over_d = 1'b0;
            winner_d    = WIN_NONE;
        end else begin
            case (state_q)
                PLAY: begin
                    if (move_take) begin
                        if (!move_legal) begin
                            illegal_d = 1'b1;
                        end else if (turn_q) begin
                            board_o_d = board_o_q | move_mask;
                        end else begin
                            board_x_d = board_x_q | move_mask;
                        end
                    end
                end
                CHECK: begin
                    if (win_x) begin
                        winner_d    = WIN_X;
                        game_over_d = 1'b1;
                    end else if (win_o) begin
                        winner_d    = WIN_O;
                        game_over_d = 1'b1;
                    end else if (board_full) begin
                        winner_d    = WIN_DRAW;
                        game_over_d = 1'b1;
                    end else begin
                        turn_d = ~turn_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.move_ready = (state_q == PLAY);
    assign bus.board_x    = board_x_q;
    assign bus.board_o    = board_o_q;
    assign bus.turn       = turn_q;
    assign bus.illegal    = illegal_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Bench for ttt_turn_controller: directed game scenarios plus a randomized
// run checked against a cell-ownership model of the game rules.
module tb_ttt_turn_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ttt_turn_controller_if bus();

    ttt_turn_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // owner: 0 empty, 1 X, 2 O; 0-based cell index = position - 1
    int         owner [9];
    bit         m_turn;
    bit         m_checking;
    bit         m_over;
    bit         m_illegal;
    logic [1:0] m_winner;

    localparam int LINES [8][3] = '{
        '{0,1,2}, '{3,4,5}, '{6,7,8},
        '{0,3,6}, '{1,4,7}, '{2,5,8},
        '{0,4,8}, '{2,4,6}
    };

    function automatic bit m_won(int who);
        for (int l = 0; l < 8; l++)
            if (owner[LINES[l][0]] == who && owner[LINES[l][1]] == who && owner[LINES[l][2]] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_full();
        for (int c = 0; c < 9; c++)
            if (owner[c] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 9; c++) owner[c] = 0;
        m_turn = 1'b0; m_checking = 1'b0; m_over = 1'b0; m_illegal = 1'b0; m_winner = 2'b00;
    endtask

    // One rising edge of the game rules with the inputs present at that edge.
    task automatic model_edge(bit ng, bit mv, int pos);
        m_illegal = 1'b0;
        if (ng) begin
            model_reset();
        end else if (m_over) begin
        end else if (m_checking) begin
            m_checking = 1'b0;
            if (m_won(1))       begin m_winner = 2'b01; m_over = 1'b1; end
            else if (m_won(2))  begin m_winner = 2'b10; m_over = 1'b1; end
            else if (m_full())  begin m_winner = 2'b11; m_over = 1'b1; end
            else                m_turn = ~m_turn;
        end else if (mv) begin
            if (pos >= 1 && pos <= 9 && owner[pos-1] == 0) begin
                owner[pos-1] = m_turn ? 2 : 1;
                m_checking = 1'b1;
            end else begin
                m_illegal = 1'b1;
            end
        end
    endtask

    function automatic logic [23:0] model_vec();
        logic [8:0] bx, bo;
        bx = '0; bo = '0;
        for (int c = 0; c < 9; c++) begin
            if (owner[c] == 1) bx[c] = 1'b1;
            if (owner[c] == 2) bo[c] = 1'b1;
        end
        return {bx, bo, m_turn, m_illegal, m_over, m_winner, !(m_checking || m_over)};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {bus.board_x, bus.board_o, bus.turn, bus.illegal, bus.game_over, bus.winner, bus.move_ready};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(bit ng, bit mv, int pos);
        bus.new_game   = ng;
        bus.move_valid = mv;
        bus.move_pos   = 4'(pos);
        @(posedge clk);
        model_edge(ng, mv, pos);
        @(negedge clk);
        bus.new_game   = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_pos   = 4'd0;
    endtask

    task automatic move(int pos);
        step(0, 1, pos);
        step(0, 0, 0);
    endtask

    task automatic do_reset();
        bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_pos = 4'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 24'h000001) begin
            errors++; $display("FAIL reset_state got %h want %h", dut_vec(), 24'h000001);
        end
    endtask

    task automatic test_x_wins_row();
        int seq [5] = '{1, 4, 2, 5, 3};
        do_reset();
        foreach (seq[i]) move(seq[i]);
        checks++;
        if (bus.board_x !== 9'h007 || bus.board_o !== 9'h018) begin
            errors++; $display("FAIL row_win_boards got x=%h o=%h want x=007 o=018", bus.board_x, bus.board_o);
        end
        checks++;
        if (bus.winner !== 2'b01 || bus.game_over !== 1'b1 || bus.move_ready !== 1'b0) begin
            errors++; $display("FAIL row_win_result got w=%b over=%b rdy=%b want w=01 over=1 rdy=0",
                               bus.winner, bus.game_over, bus.move_ready);
        end
        step(0, 1, 9);
        checks++;
        if (dut_vec() !== {9'h007, 9'h018, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0}) begin
            errors++; $display("FAIL done_ignores_move got %h", dut_vec());
        end
        step(0, 0, 0);
        checks++;
        if (dut_vec() !== {9'h007, 9'h018, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0}) begin
            errors++; $display("FAIL done_holds got %h", dut_vec());
        end
    endtask

    task automatic test_occupied();
        do_reset();
        move(5);
        step(0, 1, 5);
        checks++;
        if (bus.illegal !== 1'b1 || bus.board_o !== 9'h000 || bus.board_x !== 9'h010 ||
            bus.turn !== 1'b1 || bus.move_ready !== 1'b1) begin
            errors++; $display("FAIL occupied_reject got ill=%b x=%h o=%h turn=%b rdy=%b want 1 010 000 1 1",
                               bus.illegal, bus.board_x, bus.board_o, bus.turn, bus.move_ready);
        end
        step(0, 0, 0);
        checks++;
        if (bus.illegal !== 1'b0) begin
            errors++; $display("FAIL occupied_pulse_width got ill=%b want 0", bus.illegal);
        end
    endtask

    task automatic test_bad_codes();
        int codes [3] = '{0, 12, 15};
        foreach (codes[i]) begin
            step(0, 1, codes[i]);
            checks++;
            if (bus.illegal !== 1'b1 || bus.board_x !== 9'h010 || bus.board_o !== 9'h000 || bus.turn !== 1'b1) begin
                errors++; $display("FAIL bad_code_%0d got ill=%b x=%h o=%h turn=%b want 1 010 000 1",
                                   codes[i], bus.illegal, bus.board_x, bus.board_o, bus.turn);
            end
            step(0, 0, 0);
            checks++;
            if (bus.illegal !== 1'b0) begin
                errors++; $display("FAIL bad_code_pulse_%0d got ill=%b want 0", codes[i], bus.illegal);
            end
        end
    endtask

    task automatic test_draw();
        int seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        do_reset();
        foreach (seq[i]) move(seq[i]);
        checks++;
        if (bus.winner !== 2'b11 || bus.game_over !== 1'b1 || (bus.board_x | bus.board_o) !== 9'h1FF) begin
            errors++; $display("FAIL draw got w=%b over=%b occ=%h want 11 1 1ff",
                               bus.winner, bus.game_over, bus.board_x | bus.board_o);
        end
    endtask

    task automatic test_ninth_move_win();
        int seq [9] = '{1, 2, 3, 5, 4, 6, 8, 9, 7};
        do_reset();
        foreach (seq[i]) move(seq[i]);
        checks++;
        if (bus.winner !== 2'b01 || bus.game_over !== 1'b1 || bus.board_x !== 9'h0CD) begin
            errors++; $display("FAIL ninth_move_win got w=%b over=%b x=%h want 01 1 0cd",
                               bus.winner, bus.game_over, bus.board_x);
        end
        step(1, 0, 0);
        checks++;
        if (dut_vec() !== 24'h000001) begin
            errors++; $display("FAIL new_game_from_done got %h want 000001", dut_vec());
        end
    endtask

    task automatic test_reset_in_check();
        do_reset();
        move(1);
        step(0, 1, 5);
        checks++;
        if (bus.move_ready !== 1'b0 || bus.board_o !== 9'h010) begin
            errors++; $display("FAIL enter_check got rdy=%b o=%h want 0 010", bus.move_ready, bus.board_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 24'h000001) begin
            errors++; $display("FAIL async_reset_in_check got %h want 000001", dut_vec());
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec() !== 24'h000001) begin
            errors++; $display("FAIL after_reset_release got %h want 000001", dut_vec());
        end
    endtask

    task automatic test_new_game_with_move();
        do_reset();
        move(1);
        move(2);
        step(1, 1, 3);
        checks++;
        if (bus.board_x !== 9'h000 || bus.board_o !== 9'h000 || bus.illegal !== 1'b0 ||
            bus.turn !== 1'b0 || bus.move_ready !== 1'b1) begin
            errors++; $display("FAIL new_game_drops_move got x=%h o=%h ill=%b turn=%b rdy=%b want 000 000 0 0 1",
                               bus.board_x, bus.board_o, bus.illegal, bus.turn, bus.move_ready);
        end
    endtask

    task automatic test_hold_valid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(0, 1, i + 1);
            checks++;
            if (bus.move_ready !== logic'(i % 2 == 1)) begin
                errors++; $display("FAIL hold_valid_ready_%0d got %b want %b", i, bus.move_ready, i % 2 == 1);
            end
        end
        checks++;
        if (bus.board_x !== 9'h011 || bus.board_o !== 9'h004) begin
            errors++; $display("FAIL hold_valid_boards got x=%h o=%h want 011 004", bus.board_x, bus.board_o);
        end
    endtask

    task automatic test_random();
        bit ng, mv;
        int pos;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ng  = ($urandom_range(0, 39) == 0);
            mv  = ($urandom_range(0, 3) != 0);
            pos = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
            step(ng, mv, pos);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random_cycle_%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_pos = 4'd0;
        model_reset();
        test_reset();
        test_x_wins_row();
        test_occupied();
        test_bad_codes();
        test_draw();
        test_ninth_move_win();
        test_reset_in_check();
        test_new_game_with_move();
        test_hold_valid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttt_turn_controller.md
Name: ttt_turn_controller

Overview:
- Sequences a two-player tic-tac-toe game on a 3x3 board.
- Accepts one move per handshake, as a 1-based position code 1..9, and decodes it to a one-hot cell mask.
- Checks legality, updates the per-player occupancy registers, alternates turns, and detects win or draw.
- Sits between the input/keypad front end and the display/LED back end.

Parameters:
- FIRST_PLAYER, 1'b0, player who moves first after reset or new_game (0 = X, 1 = O).
- CELLS, 9, number of board cells. Fixed at 9; the position code width is 4.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- new_game  input  1  synchronous clear of board and state; takes priority over move_valid.
- move_valid  input  1  a move is offered on move_pos.
- move_pos  input  4  position code; 1..9 are legal, 0 and 10..15 are illegal.
- move_ready  output  1  controller can accept a move this cycle.
- board_x  output  9  cells held by X; bit n-1 corresponds to position n.
- board_o  output  9  cells held by O; same mapping.
- turn  output  1  player to move (0 = X, 1 = O).
- illegal  output  1  one-cycle pulse: offered move was rejected.
- game_over  output  1  game finished.
- winner  output  2  00 none, 01 X, 10 O, 11 draw.

Behaviour:
- Reset (rst_n low, asynchronous):
  - board_x = board_o = 0, turn = FIRST_PLAYER, illegal = 0, game_over = 0, winner = 00.
  - State = PLAY; move_ready = 1 once reset is released.
- States:
  - PLAY: move_ready = 1.
  - CHECK: move_ready = 0, one cycle.
  - DONE: move_ready = 0, game_over = 1.
- Transfer: a move is taken when move_valid && move_ready at a rising edge.
- Decode: 1..9 maps to one-hot 9-bit mask 1<<(pos-1); any other code maps to mask 0.
- Legality: mask != 0 and (mask & (board_x | board_o)) == 0.
- Legal move, edge N:
  - OR the mask into the current player's board register.
  - Go to CHECK.
  - turn is not yet toggled.
- Illegal move, edge N:
  - Boards and turn are unchanged.
  - illegal = 1 for exactly the cycle after edge N.
  - Stay in PLAY; move_ready stays 1.
- CHECK, edge N+1: evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the board just updated.
  - Line complete: winner = 01 or 10, go to DONE.
  - Else board_x | board_o == 9'h1FF: winner = 11, go to DONE.
  - Else: toggle turn, go to PLAY.
- Move-to-move latency: legal moves can be accepted at most every 2 cycles.
- DONE: all moves ignored, with no illegal pulse. Outputs hold until new_game or reset.
- new_game: sampled at any edge, in any state.
  - Clears the boards, sets turn = FIRST_PLAYER, clears winner and game_over, goes to PLAY.
  - A move presented in the same cycle is dropped, with no illegal pulse.
- Reset mid-game (including during CHECK): immediate return to reset values; no partial update survives.
- Win on the 9th move: reported as a win, never as a draw. The win test precedes the draw test.
- Outputs are all registered: board_x, board_o, turn, illegal, game_over and winner come straight from flops.

Decomposition:
- Package ttt_pkg holds:
  - Winner encodings: WIN_NONE, WIN_X, WIN_O, WIN_DRAW.
  - State encodings: PLAY, CHECK, DONE.
  - The 8 win-line masks as 9-bit constants: 007, 038, 1C0, 049, 092, 124, 111, 054.
  - Constant FULL_BOARD = 9'h1FF.
- Sub-module ttt_line_check: combinational. Input is a 9-bit board; output is 1 when any win mask is fully covered. Instantiated once per player.
- The position decode is a small case statement inside the controller.

Test Plan:
- Reset, then X plays 1, O plays 4, X 2, O 5, X 3:
  - After the final CHECK: winner = 01, game_over = 1, board_x = 9'h007, board_o = 9'h018.
  - A further move_valid in DONE leaves everything unchanged.
- X plays 5, then O offers 5:
  - illegal pulses for 1 cycle.
  - board_o = 0, turn stays 1 (O), move_ready stays 1.
- Offer move_pos = 0, then 12:
  - Each gives one illegal pulse.
  - Boards and turn are unchanged.
- Draw sequence X1 O2 X3 O5 X4 O6 X8 O7 X9:
  - winner = 11, board_x | board_o = 9'h1FF.
- Win on the 9th move, X1 O2 X3 O5 X4 O6 X8 O9 X7 (X holds 1-4-7):
  - winner = 01, not 11.
- Robustness:
  - Assert rst_n low during CHECK, asynchronously: all outputs are at reset values immediately.
  - Assert new_game together with a move_valid: boards stay 0 and no illegal pulse.
  - Hold move_valid high continuously: moves are accepted only on alternate cycles.
